// File: rtl/ofifo.sv
// Output FIFO bank behind the MAC array: one ring buffer per column, realigned
// into full rows and presented first-word-fall-through toward the SFU.
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf,
    output logic                   o_udf
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] wr_acc;
    logic           rd_acc;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    assign o_valid = &(~empty);
    assign rd_acc  = rd & o_valid;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign o_ovf   = ovf_q;
    assign o_udf   = udf_q;

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic [PW-1:0]      wp_q, wp_d;
            logic [PW-1:0]      rp_q, rp_d;
            logic [psum_bw-1:0] mem [depth];

            assign empty[gi] = (wp_q == rp_q);
            assign full[gi]  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
            // A full column frees a slot in the same cycle an accepted read retires the head.
            assign wr_acc[gi] = wr[gi] & (~full[gi] | rd_acc);

            always_comb begin
                wp_d = wp_q;
                rp_d = rp_q;
                if (wr_acc[gi]) begin
                    wp_d = wp_q + PW'(1);
                end
                if (rd_acc) begin
                    rp_d = rp_q + PW'(1);
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wp_q <= '0;
                    rp_q <= '0;
                end else begin
                    wp_q <= wp_d;
                    rp_q <= rp_d;
                end
            end

            // Storage is deliberately left out of reset; the pointers define validity.
            always_ff @(posedge clk) begin
                if (wr_acc[gi]) begin
                    mem[wp_q[AW-1:0]] <= in[gi*psum_bw +: psum_bw];
                end
            end

            assign out[gi*psum_bw +: psum_bw] = o_valid ? mem[rp_q[AW-1:0]] : '0;
        end
    endgenerate

    always_comb begin
        ovf_d = ovf_q | (|(wr & ~wr_acc));
        udf_d = udf_q | (rd & ~o_valid);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

endmodule

// File: tb/tb_ofifo.sv
// Bench for ofifo: queue-based model checked every cycle plus directed literal checks.
module tb_ofifo;

    localparam int COL   = 8;
    localparam int PBW   = 16;
    localparam int DEPTH = 64;
    localparam int OW    = COL * PBW;

    logic          clk;
    logic          reset;
    logic [OW-1:0] in;
    logic [COL-1:0] wr;
    logic          rd;
    logic [OW-1:0] out;
    logic          o_valid, o_full, o_ready, o_ovf, o_udf;

    int checks = 0;
    int errors = 0;

    ofifo #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
        .o_ovf(o_ovf), .o_udf(o_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one queue per column, sticky error bits.
    logic [PBW-1:0] mq [COL][$];
    logic m_ovf, m_udf;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
        end else begin
            automatic bit vld = 1'b1;
            automatic bit racc;
            automatic bit [COL-1:0] push = '0;
            for (int c = 0; c < COL; c++) if (mq[c].size() == 0) vld = 1'b0;
            racc = rd && vld;
            if (rd && !vld) m_udf <= 1'b1;
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (mq[c].size() < DEPTH || racc) push[c] = 1'b1;
                    else m_ovf <= 1'b1;
                end
            end
            if (racc) for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
            for (int c = 0; c < COL; c++) if (push[c]) mq[c].push_back(in[c*PBW +: PBW]);
        end
    end

    function automatic logic [OW-1:0] m_out();
        logic [OW-1:0] r = '0;
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return '0;
        for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = mq[c][0];
        return r;
    endfunction

    function automatic bit m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        chk("model_out",   out,            m_out());
        chk("model_valid", OW'(o_valid),   OW'(m_valid()));
        chk("model_full",  OW'(o_full),    OW'(m_full()));
        chk("model_ready", OW'(o_ready),   OW'(!m_full()));
        chk("model_ovf",   OW'(o_ovf),     OW'(m_ovf));
        chk("model_udf",   OW'(o_udf),     OW'(m_udf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [COL-1:0] w, input logic r, input logic [OW-1:0] d);
        wr = w;
        rd = r;
        in = d;
    endtask

    function automatic logic [OW-1:0] rep(input logic [PBW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        drive('0, 1'b0, '0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    logic [PBW-1:0] popped [$];

    initial begin
        reset = 1'b0;
        drive('0, 1'b0, '0);
        tick();
        chk("reset_valid", OW'(o_valid), OW'(0));
        chk("reset_out",   out,          '0);
        chk("reset_full",  OW'(o_full),  OW'(0));
        chk("reset_ready", OW'(o_ready), OW'(1));
        tick();
        reset = 1'b1;

        // Skewed fill
        for (int c = 0; c < COL; c++) begin
            logic [OW-1:0] d = '0;
            d[c*PBW +: PBW] = 16'h0100 + PBW'(c);
            chk("skew_not_valid", OW'(o_valid), OW'(0));
            drive(COL'(1) << c, 1'b0, d);
            tick();
        end
        drive('0, 1'b0, '0);
        chk("skew_valid", OW'(o_valid), OW'(1));
        chk("skew_row", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        drive('0, 1'b1, '0);
        tick();
        drive('0, 1'b0, '0);
        chk("skew_pop_valid", OW'(o_valid), OW'(0));
        chk("skew_pop_out",   out,          '0);

        // Streaming
        for (int i = 0; i < 12; i++) begin
            drive(i < 10 ? '1 : '0, i >= 2, i < 10 ? rep(PBW'(i)) : '0);
            if (rd && o_valid) popped.push_back(out[PBW-1:0]);
            tick();
        end
        drive('0, 1'b0, '0);
        chk("stream_count", OW'(popped.size()), OW'(10));
        for (int k = 0; k < popped.size(); k++) chk("stream_order", OW'(popped[k]), OW'(k));
        chk("stream_ovf", OW'(o_ovf), OW'(0));
        chk("stream_udf", OW'(o_udf), OW'(0));

        // Full / overflow on column 0
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            if (k == DEPTH) begin
                chk("ovf_full",     OW'(o_full),  OW'(1));
                chk("ovf_ready",    OW'(o_ready), OW'(0));
                chk("ovf_pre_flag", OW'(o_ovf),   OW'(0));
            end
            drive(COL'(1), 1'b0, rep(PBW'(k)));
            tick();
        end
        chk("ovf_flag", OW'(o_ovf), OW'(1));
        for (int k = 0; k < DEPTH; k++) begin
            drive({{(COL-1){1'b1}}, 1'b0}, 1'b0, rep(PBW'(k)));
            tick();
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive('0, 1'b1, '0);
            chk("ovf_col0_data", OW'(out[PBW-1:0]), OW'(k));
            tick();
        end
        drive('0, 1'b0, '0);
        chk("ovf_drained", OW'(o_valid), OW'(0));

        // Full with simultaneous read
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive('1, 1'b0, rep(PBW'(k)));
            tick();
        end
        chk("fullrd_full", OW'(o_full), OW'(1));
        drive('1, 1'b1, rep(16'd100));
        tick();
        drive('0, 1'b0, '0);
        chk("fullrd_still_full", OW'(o_full), OW'(1));
        chk("fullrd_ovf",        OW'(o_ovf),  OW'(0));
        chk("fullrd_head",       out,         rep(16'd1));
        for (int k = 0; k < DEPTH; k++) begin
            drive('0, 1'b1, '0);
            if (k == DEPTH - 1) chk("fullrd_last", out, rep(16'd100));
            tick();
        end

        // Underflow
        drive('0, 1'b1, '0);
        tick();
        drive('0, 1'b0, '0);
        chk("udf_flag",  OW'(o_udf),   OW'(1));
        chk("udf_valid", OW'(o_valid), OW'(0));
        chk("udf_out",   out,          '0);
        drive('1, 1'b0, rep(16'h0A0A));
        tick();
        drive('0, 1'b0, '0);
        chk("udf_after_row", out, rep(16'h0A0A));
        drive('0, 1'b1, '0);
        tick();
        drive('0, 1'b0, '0);

        // Async reset mid-stream
        for (int k = 0; k < 5; k++) begin
            drive('1, 1'b0, rep(PBW'(16'h0200 + k)));
            tick();
        end
        drive('0, 1'b0, '0);
        chk("ares_pre_valid", OW'(o_valid), OW'(1));
        chk("ares_pre_udf",   OW'(o_udf),   OW'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("ares_valid", OW'(o_valid), OW'(0));
        chk("ares_out",   out,          '0);
        chk("ares_full",  OW'(o_full),  OW'(0));
        chk("ares_ovf",   OW'(o_ovf),   OW'(0));
        chk("ares_udf",   OW'(o_udf),   OW'(0));
        tick();
        reset = 1'b1;
        drive('1, 1'b0, rep(16'h0BEE));
        tick();
        drive('0, 1'b0, '0);
        chk("ares_new_valid", OW'(o_valid), OW'(1));
        chk("ares_new_row",   out,          rep(16'h0BEE));
        drive('0, 1'b1, '0);
        tick();
        drive('0, 1'b0, '0);
        chk("ares_new_pop", OW'(o_valid), OW'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output FIFO bank directly downstream of the MAC array.
- Captures each column's psum word (col lanes of psum_bw) whenever that column's valid bit pulses; columns arrive skewed in time.
- Re-aligns the columns so a whole output row is presented at once, with a first-word-fall-through read interface toward the SFU/accumulation stage.
- Contains one independent circular buffer per column plus a shared read controller and overflow/underflow error flags.

Parameters:
- col, 8, number of columns / parallel lanes.
- psum_bw, 16, width of each psum word.
- depth, 64, entries per column buffer; must be a power of 2 and >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in  input  col*psum_bw  psum words; lane c is bits [psum_bw*(c+1)-1 : psum_bw*c], matching the array's out_s.
- wr  input  col  per-column write strobe, driven from the array's valid.
- rd  input  1  pop one full row.
- out  output  col*psum_bw  head word of every column, same lane packing as in.
- o_valid  output  1  every column non-empty, so out holds a complete row.
- o_full  output  1  at least one column is full.
- o_ready  output  1  equals !o_full.
- o_ovf  output  1  sticky: a write was dropped.
- o_udf  output  1  sticky: rd was asserted while o_valid=0.

Behaviour:
- Storage:
  - Per column c: memory of depth x psum_bw.
  - Write pointer wp[c] and read pointer rp[c], each log2(depth)+1 bits; the MSB is the wrap bit.
- Status per column:
  - empty[c] = (wp[c] == rp[c]).
  - full[c] = (LSBs equal) and (MSBs differ).
  - count[c] = wp[c] - rp[c], modulo 2^(log2(depth)+1).
- Read accept: rd_acc = rd & o_valid.
  - rd_acc increments every rp[c] by 1 in the same cycle.
  - rd while o_valid=0 does nothing except set o_udf.
- Write accept per column: wr_acc[c] = wr[c] & (!full[c] | rd_acc).
  - A full column still accepts a write in the same cycle as an accepted read.
  - wr_acc[c] stores in lane c at mem[c][wp[c] LSBs] and increments wp[c].
  - wr[c] & !wr_acc[c]: the write is dropped, wp[c] is unchanged, and o_ovf is set.
- Columns write independently; any subset of wr bits may be high in a cycle.
- Wrap-around is automatic through pointer overflow: after depth writes the pointer LSBs return to 0 and the wrap bit toggles.
- Outputs:
  - o_valid = AND over all !empty[c]. Combinational from registered pointers, no input-to-output path.
  - out (first-word-fall-through): lane c = mem[c][rp[c] LSBs] when o_valid=1; all zeros when o_valid=0.
  - out stays stable while o_valid=1 and rd=0.
  - After an accepted read, the next row appears on the following cycle if every column still has data.
- Latency: a row whose last column is written at edge N drives o_valid=1 and out in the cycle after edge N (one cycle of write-to-read latency).
- o_full / o_ready are derived from the pointers, registered state only.
- Reset (reset=0, asynchronous):
  - All wp/rp are cleared to 0, and o_ovf and o_udf are cleared.
  - Outputs then read o_valid=0, out=0, o_full=0, o_ready=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all buffered data immediately. The first edge after deassertion behaves as a fresh, empty FIFO.
- The only way to clear the sticky flags is reset.
- No state machine beyond the pointer logic; each column is an independent ring, with the read side gated by the all-columns-non-empty condition.

Test Plan:
- Skewed fill: after reset, assert wr[c] at cycle c for c=0..7 with lane c=16'h0100+c → o_valid stays 0 until the cycle after wr[7], then out = {16'h0107,...,16'h0100}. Pulse rd → o_valid=0 and out=0 next cycle.
- Streaming: wr=8'hFF for 10 cycles with lane data = cycle index, rd held at 1 from cycle 2 → rows pop in order 0..9, no row skipped or duplicated, o_ovf=0 and o_udf=0 throughout.
- Full/overflow: wr=8'h01 for 65 cycles, data 0..64, rd=0 → o_full=1 after 64 writes. The 65th write (64) is dropped and o_ovf=1. Then fill columns 1..7 and read 64 rows → column 0 yields 0..63.
- Full with simultaneous read: fill all columns to 64, then drive wr=8'hFF, rd=1 in the same cycle → read accepted, write accepted, o_full stays 1, o_ovf=0.
- Underflow: rd=1 while empty → o_udf=1, pointers unchanged, out=0. A later valid row still reads correctly.
- Async reset mid-stream: after 5 buffered rows, pull reset low between clock edges → o_valid=0, out=0, o_full=0 and o_ovf=0 without waiting for a clock edge. After release, the first new row reads back correctly.
